boot_ctrl: RTL and testbench
============================

# boot_ctrl

Bootloader sequencer for the instruction memory. It receives a byte stream from the UART receiver and parses a length header. It assembles little-endian 32-bit words and drives the instruction memory's boot write port (`wdata_data`, `wdata_addr`, `we_boot`). It holds `bootloading` high so instruction fetch is frozen while the image is written.

## Interface
- `ADDRW`, 11, boot write address is `ADDRW+1` bits; maximum image = 2^(ADDRW+1) words (4096 default)
- `clk` input 1 — global clock; all state updates on posedge
- `rst` input 1 — asynchronous, active-high reset
- `boot_start` input 1 — request to begin loading; sampled only in IDLE or DONE
- `rx_data` input 8 — received byte
- `rx_valid` input 1 — one-cycle strobe, `rx_data` valid
- `wdata_data` output 32 — assembled word to I-mem
- `wdata_addr` output ADDRW+1 — word index to I-mem
- `we_boot` output 1 — one-cycle write strobe
- `bootloading` output 1 — high while an image load is in progress
- `boot_done` output 1 — level, load finished (success or error)
- `boot_err` output 1 — level, valid with `boot_done`

## Operation
- Stream format, all fields little-endian (first byte → bits [7:0]):
  - 4-byte word count N
  - N data words
  - a 4-byte checksum trailer, when the checksum feature is compiled in
- States: IDLE, LEN, DATA, CHK, DONE.
- **IDLE:** outputs low. `boot_start`=1 → LEN, clear byte counter, word index, running sum, `boot_err`.
- **LEN:**
  - Each `rx_valid` shifts a byte in; the 2-bit byte counter wraps 3→0.
  - On the 4th byte:
    - N > 2^(ADDRW+1) → DONE with `boot_err`=1, no writes.
    - N == 0 → CHK (checksum build) or DONE.
    - Otherwise → DATA.
- **DATA:**
  - On the 4th byte of a word, load `wdata_data` with the assembled word and `wdata_addr` with the word index.
  - Pulse `we_boot` in the next cycle.
  - Increment the word index and add the word to the running sum (mod 2^32).
  - After word N-1 → CHK or DONE.
- **CHK:** collect 4 bytes and compare with the running sum. On mismatch set `boot_err`=1. → DONE.
- **DONE:**
  - `boot_done`=1 and `bootloading`=0.
  - `boot_err` holds its value.
  - `boot_start`=1 → LEN with a full restart (`boot_done` and `boot_err` cleared).
- `rx_valid` is ignored in IDLE and DONE.
- `boot_start` is ignored in LEN, DATA and CHK.
- A byte arriving in the same cycle as a `we_boot` pulse is accepted. The byte shift register is separate from the `wdata_data` output register.
- `wdata_data` and `wdata_addr` hold their last values between writes.

## Timing
- Reset values: `wdata_data`=0, `wdata_addr`=0, `we_boot`=0, `bootloading`=0, `boot_done`=0, `boot_err`=0; state=IDLE.
- `bootloading` rises the cycle after `boot_start` is sampled. It falls in the same cycle `boot_done` rises.
- Write latency: `we_boot` is high exactly 1 cycle, the cycle after the posedge that accepted the word's 4th byte.
- `wdata_*` and `we_boot` are registered on posedge, so they are stable at the I-mem negedge write.
- The final `we_boot` pulse occurs while `bootloading`=1, even when the state transitions to DONE in that same cycle.
- Minimum byte spacing is 1 cycle: back-to-back `rx_valid` is supported with no loss.
- `rst` mid-load returns to IDLE immediately and asynchronously. I-mem words already written are left as is.

## Configuration
- `BOOT_CHKSUM_EN` defined:
  - CHK state and 32-bit running-sum adder are present.
  - A 4-byte trailer is mandatory.
  - A mismatch sets `boot_err`.
- Not defined:
  - No CHK state and no adder.
  - DATA (or LEN when N=0) goes directly to DONE.
  - `boot_err` can only be set by an oversize N.

## Test plan
- **Basic load:** reset, pulse `boot_start`, then send N=2 and words 0x00000013, 0xDEADBEEF back-to-back; with `BOOT_CHKSUM_EN`, append trailer 0xDEADBF02.
  - Two `we_boot` pulses: addr 0 / data 0x00000013, then addr 1 / data 0xDEADBEEF.
  - `boot_done`=1, `boot_err`=0, `bootloading` falls.
- **Checksum mismatch (`BOOT_CHKSUM_EN`):** same image with trailer 0x00000000 → both writes occur, `boot_done`=1, `boot_err`=1.
- **Oversize length:** N=4097 with ADDRW=11 → no `we_boot`, DONE with `boot_err`=1 immediately after the 4th header byte.
- **Sparse bytes and ignored start:** bytes spaced 5 cycles apart, `boot_start` pulsed mid-DATA.
  - The start pulse is ignored.
  - Byte order is preserved (bytes 0x11, 0x22, 0x33, 0x44 → word 0x44332211).
- **Reset mid-load:** assert `rst` after the 2nd data word's 2nd byte.
  - All outputs return to 0 and state is IDLE.
  - A subsequent `boot_start` with N=1 writes addr 0 correctly.

Source files
------------

// File: rtl/boot_ctrl.sv
// ---------------------------------------------------------------------------
// boot_ctrl -- bootloader sequencer for the instruction memory.
//
// Parses a byte stream from the UART receiver: a little-endian 32-bit word
// count N, then N little-endian data words (and, when the checksum feature is
// compiled in, a 4-byte little-endian trailer holding the mod-2^32 sum of the
// data words). Each assembled word is written to the I-mem boot port.
// Instruction fetch stays frozen (bootloading=1) while the image is written.
//
// Optional feature macro: BOOT_CHKSUM_EN
//   defined   : CHK state and 32-bit running-sum adder present, trailer
//               mandatory, a mismatch sets boot_err.
//   undefined : no CHK state, no adder; boot_err only flags an oversize N.
//
// Parameters:
//   ADDRW        boot write address is ADDRW+1 bits; max image 2^(ADDRW+1) words
//
// Ports:
//   clk          global clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   boot_start   request to (re)start a load; sampled in IDLE or DONE only
//   rx_data      received byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   wdata_data   assembled word to I-mem (holds between writes)
//   wdata_addr   word index to I-mem (holds between writes)
//   we_boot      one-cycle write strobe, registered
//   bootloading  high while an image load is in progress
//   boot_done    level, load finished (success or error)
//   boot_err     level, valid together with boot_done
// ---------------------------------------------------------------------------
module boot_ctrl #(
  parameter int ADDRW = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [31:0]      wdata_data,
  output logic [ADDRW:0]   wdata_addr,
  output logic             we_boot,
  output logic             bootloading,
  output logic             boot_done,
  output logic             boot_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef BOOT_CHKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd3;
  // State entered once all data words are in (or straight after N=0).
  localparam logic [2:0] S_AFTER = S_CHK;
`else
  localparam logic [2:0] S_AFTER = 3'd4;
`endif
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDRW+1:0] MAX_WORDS = {1'b1, {(ADDRW+1){1'b0}}};

  logic [2:0]       state;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift_q;      // first three bytes of the current field
  logic [ADDRW+1:0] word_idx;     // one bit wider than the address so N=max fits
  logic [ADDRW+1:0] len_q;
  logic [31:0]      assembled;
  logic [ADDRW+1:0] word_idx_nxt;
  logic             active;
  logic             oversize;
  logic             start_ok;

`ifdef BOOT_CHKSUM_EN
  logic [31:0]      sum_q;
  assign active = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
`else
  assign active = (state == S_LEN) || (state == S_DATA);
`endif

  // The 4th byte completes the field: it lands in bits [31:24].
  assign assembled    = {rx_data, shift_q};
  assign word_idx_nxt = word_idx + 1'b1;
  assign oversize     = (|assembled[31:ADDRW+2]) || (assembled[ADDRW+1:0] > MAX_WORDS);
  assign start_ok     = boot_start && ((state == S_IDLE) || (state == S_DONE));

  // The last write pulse completes while fetch is still frozen, so the
  // pending we_boot extends bootloading and delays boot_done by that cycle.
  assign bootloading = active || we_boot;
  assign boot_done   = (state == S_DONE) && !we_boot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      len_q      <= '0;
      boot_err   <= 1'b0;
      we_boot    <= 1'b0;
      wdata_data <= 32'd0;
      wdata_addr <= '0;
    end else begin
      we_boot <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (boot_start) begin
            state    <= S_LEN;
            byte_cnt <= 2'd0;
            word_idx <= '0;
            boot_err <= 1'b0;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              len_q <= assembled[ADDRW+1:0];
              if (oversize) begin
                boot_err <= 1'b1;
                state    <= S_DONE;
              end else if (assembled == 32'd0) begin
                state <= S_AFTER;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wdata_data <= assembled;
              wdata_addr <= word_idx[ADDRW:0];
              we_boot    <= 1'b1;
              word_idx   <= word_idx_nxt;
              if (word_idx_nxt == len_q) state <= S_AFTER;
            end
          end
        end
`ifdef BOOT_CHKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (assembled != sum_q) boot_err <= 1'b1;
              state <= S_DONE;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte shift register and running sum: datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (rx_valid && active) shift_q <= {rx_data, shift_q[23:8]};
`ifdef BOOT_CHKSUM_EN
    if (start_ok)
      sum_q <= 32'd0;
    else if ((state == S_DATA) && rx_valid && (byte_cnt == 2'd3))
      sum_q <= sum_q + assembled;
`endif
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boot_ctrl -- self-checking bench for boot_ctrl (ADDRW=11).
// Expected writes are queued when a word's bytes are driven and popped by a
// negedge monitor whenever we_boot is seen. Image loads come from a vector
// table; multi-cycle corners are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_boot_ctrl;

  localparam int ADDRW = 11;
`ifdef BOOT_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             boot_start = 1'b0;
  logic [7:0]       rx_data = 8'd0;
  logic             rx_valid = 1'b0;
  logic [31:0]      wdata_data;
  logic [ADDRW:0]   wdata_addr;
  logic             we_boot;
  logic             bootloading;
  logic             boot_done;
  logic             boot_err;

  boot_ctrl #(.ADDRW(ADDRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .boot_start (boot_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wdata_data (wdata_data),
    .wdata_addr (wdata_addr),
    .we_boot    (we_boot),
    .bootloading(bootloading),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDRW:0] addr;
    logic [31:0]    data;
  } wr_t;

  typedef struct {
    logic [31:0] n;        // header value
    int          nsend;    // data words actually sent
    logic [31:0] seed;
    int          gap;      // idle cycles after each byte
    bit          bad_chk;  // corrupt the trailer
    bit          trailer;  // send a trailer (checksum builds only)
    bit          exp_err;
  } vec_t;

  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every pulse must match the oldest queued expectation and
  // must occur with fetch still frozen.
  always @(negedge clk) begin
    if (!rst && we_boot) begin
      writes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 wdata_addr, wdata_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write_addr", 64'(wdata_addr), 64'(e.addr));
        chk("write_data", 64'(wdata_data), 64'(e.data));
        chk("write_bootloading", 64'(bootloading), 64'd1);
        chk("write_not_done", 64'(boot_done), 64'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // All drivers below assume they are entered at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (!boot_done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(boot_done), 64'd1);
  endtask

  function automatic logic [31:0] gen_word(input logic [31:0] seed, input int i);
    return seed + 32'(i) * 32'h9E37_79B9;
  endfunction

  task automatic load_image(input logic [31:0] n, input int nsend, input logic [31:0] seed,
                            input int gap, input bit bad, input bit trl);
    logic [31:0] sum;
    logic [31:0] w;
    sum = 32'd0;
    send_word(n, gap);
    for (int i = 0; i < nsend; i++) begin
      w = gen_word(seed, i);
      sb.push_back({i[ADDRW:0], w});
      sum = sum + w;
      send_word(w, gap);
    end
    if (CHK_EN && trl) send_word(bad ? ~sum : sum, gap);
  endtask

  vec_t vecs[7];

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    chk("rst_wdata_data", 64'(wdata_data), 64'd0);
    chk("rst_wdata_addr", 64'(wdata_addr), 64'd0);
    chk("rst_we_boot", 64'(we_boot), 64'd0);
    chk("rst_bootloading", 64'(bootloading), 64'd0);
    chk("rst_boot_done", 64'(boot_done), 64'd0);
    chk("rst_boot_err", 64'(boot_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // IDLE ignores bytes: a stray byte must not count toward the header.
    send_byte(8'hAA, 0);
    chk("idle_bootloading", 64'(bootloading), 64'd0);

    // ---------------- basic load ----------------
    pulse_start();
    chk("start_bootloading", 64'(bootloading), 64'd1);
    chk("start_done_low", 64'(boot_done), 64'd0);
    sb.push_back({12'd0, 32'h0000_0013});
    sb.push_back({12'd1, 32'hDEAD_BEEF});
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'hDEAD_BEEF, 0);
    if (CHK_EN) send_word(32'hDEAD_BF02, 0);
    wait_done("basic_done", 20);
    chk("basic_err", 64'(boot_err), 64'd0);
    chk("basic_bootloading", 64'(bootloading), 64'd0);
    chk("basic_all_written", 64'(sb.size()), 64'd0);
    chk("basic_hold_addr", 64'(wdata_addr), 64'd1);
    chk("basic_hold_data", 64'(wdata_data), 64'hDEAD_BEEF);

    // Checksum mismatch on the same image.
    if (CHK_EN) begin
      pulse_start();
      chk("mm_done_cleared", 64'(boot_done), 64'd0);
      sb.push_back({12'd0, 32'h0000_0013});
      sb.push_back({12'd1, 32'hDEAD_BEEF});
      send_word(32'd2, 0);
      send_word(32'h0000_0013, 0);
      send_word(32'hDEAD_BEEF, 0);
      send_word(32'h0000_0000, 0);
      wait_done("mm_done", 20);
      chk("mm_err", 64'(boot_err), 64'd1);
      chk("mm_all_written", 64'(sb.size()), 64'd0);
    end

    // ---------------- table-driven loads ----------------
    vecs[0] = '{32'd2,          2, 32'h1234_5678, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'd1,          1, 32'hCAFE_0001, 2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'd3,          3, 32'h0BAD_F00D, 0, 1'b1, 1'b1, CHK_EN};
    vecs[3] = '{32'd0,          0, 32'h0,         0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'd4097,       0, 32'h0,         0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_0002,  0, 32'h0,         1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'd3,          3, 32'hFFFF_FFFF, 1, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 7; v++) begin
      int w0;
      w0 = writes;
      pulse_start();
      load_image(vecs[v].n, vecs[v].nsend, vecs[v].seed, vecs[v].gap,
                 vecs[v].bad_chk, vecs[v].trailer);
      wait_done($sformatf("vec%0d_done", v), 20);
      chk($sformatf("vec%0d_err", v), 64'(boot_err), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_bootloading", v), 64'(bootloading), 64'd0);
      chk($sformatf("vec%0d_writes", v), 64'(writes - w0), 64'(vecs[v].nsend));
      chk($sformatf("vec%0d_queue", v), 64'(sb.size()), 64'd0);
    end

    // ---------------- oversize: DONE right after the 4th header byte ----------------
    pulse_start();
    send_word(32'd4097, 0);
    chk("over_done_now", 64'(boot_done), 64'd1);
    chk("over_err_now", 64'(boot_err), 64'd1);
    chk("over_bootloading", 64'(bootloading), 64'd0);
    // Bytes after DONE are ignored: nothing is written.
    send_word(32'h1111_1111, 0);
    chk("over_no_write", 64'(sb.size()), 64'd0);

    // ---------------- maximum image (N = 2^(ADDRW+1)) ----------------
    begin
      int w0;
      w0 = writes;
      pulse_start();
      load_image(32'd4096, 4096, 32'h0000_1000, 0, 1'b0, 1'b1);
      wait_done("max_done", 20);
      chk("max_err", 64'(boot_err), 64'd0);
      chk("max_writes", 64'(writes - w0), 64'd4096);
      chk("max_last_addr", 64'(wdata_addr), 64'hFFF);
    end

    // ---------------- sparse bytes with an ignored start mid-DATA ----------------
    pulse_start();
    sb.push_back({12'd0, 32'h4433_2211});
    sb.push_back({12'd1, 32'hA5A5_5A5A});
    send_word(32'd2, 5);
    send_byte(8'h11, 5);
    send_byte(8'h22, 5);
    send_byte(8'h33, 5);
    send_byte(8'h44, 5);
    send_byte(8'h5A, 5);
    send_byte(8'h5A, 2);
    pulse_start();
    chk("sparse_still_loading", 64'(bootloading), 64'd1);
    send_byte(8'hA5, 5);
    send_byte(8'hA5, 5);
    if (CHK_EN) send_word(32'h4433_2211 + 32'hA5A5_5A5A, 5);
    wait_done("sparse_done", 20);
    chk("sparse_err", 64'(boot_err), 64'd0);
    chk("sparse_queue", 64'(sb.size()), 64'd0);

    // ---------------- reset mid-load ----------------
    pulse_start();
    sb.push_back({12'd0, 32'h0101_0101});
    send_word(32'd3, 0);
    send_word(32'h0101_0101, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_wdata_data", 64'(wdata_data), 64'd0);
    chk("mid_rst_wdata_addr", 64'(wdata_addr), 64'd0);
    chk("mid_rst_bootloading", 64'(bootloading), 64'd0);
    chk("mid_rst_done", 64'(boot_done), 64'd0);
    chk("mid_rst_err", 64'(boot_err), 64'd0);
    chk("mid_rst_queue", 64'(sb.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(bootloading), 64'd0);
    pulse_start();
    load_image(32'd1, 1, 32'h7654_3210, 0, 1'b0, 1'b1);
    wait_done("post_rst_done", 20);
    chk("post_rst_err", 64'(boot_err), 64'd0);
    chk("post_rst_addr", 64'(wdata_addr), 64'd0);
    chk("post_rst_queue", 64'(sb.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
